// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: 1 ms tick prescaler, per-button event classifier
// (PRESS/RELEASE/LONG/REPEAT), per-button pending slots and round-robin event port.

module btn_event_lane #(
  parameter int LONG_MS = 1000,
  parameter int REP_MS  = 200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_db,
  output logic       o_emit,
  output logic [1:0] o_type
);
  localparam logic [1:0]  EVT_PRESS = 2'd0;
  localparam logic [1:0]  EVT_REL   = 2'd1;
  localparam logic [1:0]  EVT_LONG  = 2'd2;
  localparam logic [1:0]  EVT_REP   = 2'd3;
  localparam logic [15:0] LONG_END  = 16'(LONG_MS - 1);
  localparam logic [15:0] REP_END   = 16'(REP_MS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_RPT = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_prev;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        w_rise, w_fall;

  assign w_rise = i_db & ~r_prev;
  assign w_fall = ~i_db & r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= i_db;
    end
  end

  // Release wins over a coincident tick, so no LONG/REPEAT on the release cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_rise) begin
        w_state_nxt = S_HELD;
        w_cnt_nxt   = '0;
      end
      S_HELD: begin
        if (w_fall) w_state_nxt = S_IDLE;
        else if (i_tick) begin
          if (r_cnt == LONG_END) begin
            w_state_nxt = S_RPT;
            w_cnt_nxt   = '0;
          end else w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RPT: begin
        if (w_fall) w_state_nxt = S_IDLE;
        else if (i_tick) w_cnt_nxt = (r_cnt == REP_END) ? 16'd0 : r_cnt + 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_emit = 1'b0;
    o_type = EVT_PRESS;
    case (r_state)
      S_IDLE: o_emit = w_rise;
      S_HELD: begin
        if (w_fall) begin
          o_emit = 1'b1;
          o_type = EVT_REL;
        end else if (i_tick && r_cnt == LONG_END) begin
          o_emit = 1'b1;
          o_type = EVT_LONG;
        end
      end
      S_RPT: begin
        if (w_fall) begin
          o_emit = 1'b1;
          o_type = EVT_REL;
        end else if (i_tick && r_cnt == REP_END) begin
          o_emit = 1'b1;
          o_type = EVT_REP;
        end
      end
      default: o_emit = 1'b0;
    endcase
  end
endmodule

module btn_event_ctrl #(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = 100000,
  parameter int LONG_MS  = 1000,
  parameter int REP_MS   = 200
) (
  input  logic             clk_100Mhz,
  input  logic             rst,
  output logic             tick,
  input  logic [N_BTN-1:0] btn_db,
  output logic             evt_valid,
  output logic [2:0]       evt_btn,
  output logic [1:0]       evt_type,
  input  logic             evt_ack,
  output logic             ovf
);
  localparam logic [1:0]  EVT_REL  = 2'd1;
  localparam logic [16:0] PRESC_END = 17'(TICK_DIV - 1);

  logic [16:0]           r_presc;
  logic [N_BTN-1:0]      w_emit;
  logic [N_BTN-1:0][1:0] w_type;
  logic [N_BTN-1:0]      r_slot_v;
  logic [N_BTN-1:0][1:0] r_slot_t;
  logic [N_BTN-1:0]      w_drain;
  logic [2:0]            r_ptr, w_ptr_nxt;
  logic                  w_load, w_gnt_v, w_ovf_set;
  logic [2:0]            w_gnt_idx;
  logic [1:0]            w_gnt_type;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst)                     r_presc <= '0;
    else if (r_presc == PRESC_END) r_presc <= '0;
    else                         r_presc <= r_presc + 17'd1;
  end

  assign tick = (r_presc == PRESC_END);

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_event_lane #(.LONG_MS(LONG_MS), .REP_MS(REP_MS)) u_lane (
      .i_clk  (clk_100Mhz),
      .i_rst  (rst),
      .i_tick (tick),
      .i_db   (btn_db[g]),
      .o_emit (w_emit[g]),
      .o_type (w_type[g])
    );
  end

  assign w_load = ~evt_valid | evt_ack;

  // Scan offsets from the pointer outward; the first valid slot wins.
  always_comb begin
    w_gnt_v    = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_type = '0;
    for (int k = 0; k < N_BTN; k++)
      for (int j = 0; j < N_BTN; j++)
        if (!w_gnt_v && r_slot_v[j] && ((int'(r_ptr) + k) % N_BTN) == j) begin
          w_gnt_v    = 1'b1;
          w_gnt_idx  = 3'(j);
          w_gnt_type = r_slot_t[j];
        end
    for (int j = 0; j < N_BTN; j++)
      w_drain[j] = w_load & w_gnt_v & (w_gnt_idx == 3'(j));
    w_ptr_nxt = (w_gnt_idx == 3'(N_BTN - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
  end

  assign w_ovf_set = |(w_emit & r_slot_v & ~w_drain);

  // A slot drained this cycle is free for the new event; RELEASE always overwrites.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_slot_v <= '0;
      r_slot_t <= '0;
    end else begin
      for (int j = 0; j < N_BTN; j++) begin
        if (w_emit[j] && (!r_slot_v[j] || w_drain[j] || w_type[j] == EVT_REL)) begin
          r_slot_v[j] <= 1'b1;
          r_slot_t[j] <= w_type[j];
        end else if (w_drain[j]) begin
          r_slot_v[j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      evt_valid <= w_gnt_v;
      if (w_gnt_v) begin
        evt_btn  <= w_gnt_idx;
        evt_type <= w_gnt_type;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst)            ovf <= 1'b0;
    else if (w_ovf_set) ovf <= 1'b1;
  end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Randomized + directed bench for btn_event_ctrl against an event-level reference model.

module tb_btn_event_ctrl;
  localparam int N  = 4;
  localparam int TD = 10;
  localparam int LM = 5;
  localparam int RM = 3;

  logic         clk_100Mhz = 1'b0;
  logic         rst = 1'b1;
  logic         tick;
  logic [N-1:0] btn_db = '0;
  logic         evt_valid;
  logic [2:0]   evt_btn;
  logic [1:0]   evt_type;
  logic         evt_ack = 1'b0;
  logic         ovf;

  btn_event_ctrl #(.N_BTN(N), .TICK_DIV(TD), .LONG_MS(LM), .REP_MS(RM)) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .tick       (tick),
    .btn_db     (btn_db),
    .evt_valid  (evt_valid),
    .evt_btn    (evt_btn),
    .evt_type   (evt_type),
    .evt_ack    (evt_ack),
    .ovf        (ovf)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: buttons tracked as held/not-held plus ticks elapsed since press;
  // pending events are a per-button mailbox drained in rotating order.
  int       m_cyc;
  bit       m_held [N];
  int       m_nt   [N];
  bit       m_pv   [N];
  bit [1:0] m_pt   [N];
  int       m_ptr;
  bit       m_ev;
  int       m_eb;
  bit [1:0] m_et;
  bit       m_ovf;
  int       seen   [4];

  task automatic model_reset();
    m_cyc = 0; m_ptr = 0; m_ev = 0; m_eb = 0; m_et = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) begin
      m_held[i] = 0; m_nt[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit       tk;
    bit       ev [N];
    bit [1:0] et [N];
    bit       found;
    int       g;
    tk = (m_cyc % TD) == TD - 1;
    for (int i = 0; i < N; i++) begin
      ev[i] = 0; et[i] = 0;
      if (!m_held[i]) begin
        if (btn_db[i]) begin ev[i] = 1; et[i] = 0; m_held[i] = 1; m_nt[i] = 0; end
      end else if (!btn_db[i]) begin
        ev[i] = 1; et[i] = 1; m_held[i] = 0;
      end else if (tk) begin
        m_nt[i]++;
        if (m_nt[i] == LM) begin ev[i] = 1; et[i] = 2; end
        else if (m_nt[i] > LM && (m_nt[i] - LM) % RM == 0) begin ev[i] = 1; et[i] = 3; end
      end
    end
    if (!m_ev || evt_ack) begin
      found = 0; g = 0;
      for (int k = 0; k < N; k++)
        if (!found && m_pv[(m_ptr + k) % N]) begin found = 1; g = (m_ptr + k) % N; end
      m_ev = found;
      if (found) begin
        m_eb = g; m_et = m_pt[g]; m_pv[g] = 0; m_ptr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++)
      if (ev[i]) begin
        if (m_pv[i]) begin
          m_ovf = 1;
          if (et[i] == 1) m_pt[i] = 1;
        end else begin
          m_pv[i] = 1; m_pt[i] = et[i];
        end
      end
    m_cyc++;
  endtask

  task automatic check_all();
    chk("tick", tick, 32'((m_cyc % TD) == TD - 1));
    chk("evt_valid", evt_valid, 32'(m_ev));
    chk("evt_btn", evt_btn, 32'(m_eb));
    chk("evt_type", evt_type, 32'(m_et));
    chk("ovf", ovf, 32'(m_ovf));
    if (evt_valid && evt_btn == 3'd1) seen[evt_type]++;
  endtask

  task automatic cyc(input logic [N-1:0] b, input logic a);
    btn_db  = b;
    evt_ack = a;
    @(posedge clk_100Mhz);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_btn"}, evt_btn, 0);
    chk({tag, "_type"}, evt_type, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // Called one time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    model_reset();
    @(posedge clk_100Mhz);
    #1 rst = 1'b0;
  endtask

  logic [N-1:0] b;
  int           guard;
  int           rate;

  initial begin
    model_reset();
    repeat (2) @(posedge clk_100Mhz);
    #1 chk_reset_vals("rst_init");
    rst = 1'b0;

    // 1: idle, tick cadence
    for (int c = 0; c < 35; c++) cyc('0, 1'b0);

    // 2: single press with ack high
    cyc(4'b0100, 1'b1);
    cyc(4'b0100, 1'b1);
    chk("s2_valid", evt_valid, 1);
    chk("s2_btn", evt_btn, 2);
    chk("s2_type", evt_type, 0);
    cyc(4'b0100, 1'b1);
    chk("s2_drop", evt_valid, 0);
    cyc(4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) cyc('0, 1'b1);

    // 3: long hold on btn 1, release coincident with a tick
    for (int t = 0; t < 4; t++) seen[t] = 0;
    guard = 0;
    cyc(4'b0010, 1'b1);
    while (m_nt[1] < 14 && guard < 500) begin cyc(4'b0010, 1'b1); guard++; end
    while ((m_cyc % TD) != TD - 1 && guard < 500) begin cyc(4'b0010, 1'b1); guard++; end
    chk("s3_guard", 32'(guard < 500), 1);
    cyc(4'b0000, 1'b1);
    for (int c = 0; c < 4; c++) cyc('0, 1'b1);
    chk("s3_press", seen[0], 1);
    chk("s3_long", seen[2], 1);
    chk("s3_repeat", seen[3], 3);
    chk("s3_release", seen[1], 1);

    // 4: simultaneous presses, then again with the pointer elsewhere
    do_reset();
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b1);
    chk("s4_first", evt_btn, 0);
    cyc(4'b1001, 1'b1);
    chk("s4_second", evt_btn, 3);
    cyc(4'b0000, 1'b1);
    cyc(4'b0010, 1'b1);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1);
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b1);
    for (int c = 0; c < 3; c++) cyc(4'b0000, 1'b1);

    // 5: overflow with ack held low
    do_reset();
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("s5_ovf", ovf, 1);
    for (int c = 0; c < 3; c++) cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) cyc(4'b0000, 1'b1);
    chk("s5_ovf_sticky", ovf, 1);

    // 6: reset while btn 1 is repeating with an event pending
    do_reset();
    guard = 0;
    cyc(4'b0010, 1'b0);
    while (m_nt[1] < 7 && guard < 500) begin cyc(4'b0010, 1'b0); guard++; end
    chk("s6_pending", evt_valid, 1);
    btn_db = '0;
    do_reset();
    for (int c = 0; c < 25; c++) cyc('0, 1'b1);
    chk("s6_quiet", evt_valid, 0);

    // Random phases: slow/fast toggling, varying ack duty, occasional resets
    b = '0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      rate = ((c / 600) % 2 == 1) ? 5 : 70;
      for (int i = 0; i < N; i++) if ($urandom_range(0, rate) == 0) b[i] = ~b[i];
      cyc(b, ((c / 900) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
